pending_event_encoder_32x5: RTL and testbench
=============================================

Name: pending_event_encoder_32x5

Overview:
- Downstream consumer of the 5x32 decoder's one-hot word.
- Latches each asserted line into a 32-bit pending register.
- Re-encodes the pending lines one at a time into a 5-bit index, presented over a valid/ready handshake.
- Turns bursts of decoded strobes into an ordered, back-pressurable stream of indices for the next stage.

Parameters:
- N_LINES, 32, number of event lines (width of decoder word); must equal 2**IDX_W.
- IDX_W, 5, index width.
- RR_MODE, 1, arbitration: 1 = round-robin from rotating pointer, 0 = fixed priority (lowest index first).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- word_in  input  N_LINES  event strobes from decoder; any bit pattern is legal, not only one-hot.
- word_en  input  1  qualifies word_in; word_in ignored when 0.
- idx_out  output  IDX_W  index of the event being offered.
- idx_valid  output  1  idx_out is valid.
- idx_ready  input  1  consumer accepts; handshake = idx_valid & idx_ready at a rising edge.
- pending  output  N_LINES  current pending register (registered).
- overflow  output  1  sticky: an event hit a line already pending.
- clr_overflow  input  1  clears overflow.

Behaviour:
- Reset (rst=1 at edge) clears all state, overriding all other inputs:
  - pending=0, idx_out=0, idx_valid=0, pointer=0, overflow=0, FSM=IDLE.
  - Reset mid-offer drops the offered index and all pending events; nothing is replayed.
- Pending update, each edge:
  - pending_next = (pending & ~clr_mask) | (word_en ? word_in : 0).
  - clr_mask = onehot(idx_out) on a handshake, else 0.
  - Set wins over clear on the same bit: the bit stays pending and is offered again later.
- Overflow is set at an edge when word_en & word_in[i] & pending[i] & ~clr_mask[i] for any i.
  - Sticky until clr_overflow.
  - Set wins if set and clr_overflow coincide.
- Arbitration over candidate vector C:
  - RR_MODE=1: first set bit of C searching upward from pointer, wrapping 31->0.
  - RR_MODE=0: lowest set bit of C.
  - On each handshake, pointer <= idx_out+1 mod 32 (31 wraps to 0); pointer is unused when RR_MODE=0.
- FSM states:
  - IDLE: idx_valid=0. If registered pending != 0, load idx_out = arb(pending) and go to OFFER. Else stay.
  - OFFER: idx_valid=1.
    - idx_out and idx_valid are held stable until handshake, regardless of new events.
    - On handshake, let C = pending & ~onehot(idx_out), using the registered pending; events arriving the same cycle are not considered.
    - If C != 0: load idx_out = arb(C) with the updated pointer and stay in OFFER (back-to-back, one index per cycle).
    - Else go to IDLE.
- Latency and throughput:
  - An event sampled at edge k sets pending after edge k.
  - Earliest idx_valid is after edge k+1: 2 edges from input to offer when idle.
  - Sustained throughput is 1 index per cycle with idx_ready held high.
- idx_ready while idx_valid=0 has no effect.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset then single event: word_en=1, word_in=32'h0000_0100 for one cycle, idx_ready=1 → pending=32'h100 after edge 1; idx_valid=1, idx_out=8 after edge 2; pending=0, idx_valid=0 after edge 3; overflow=0.
- Burst with backpressure, RR_MODE=1, pointer=0: events at bits 3, 17, 30 in three cycles, idx_ready=0 for 5 cycles then 1 → idx_out holds 3 while stalled, then 3,17,30 on consecutive cycles; idx_valid drops after 30.
- Round-robin wrap: pointer at 31 (after granting 30), pending bits 2 and 31 → order 31 then 2; pointer becomes 3. With RR_MODE=0 the same vector yields 2 then 31.
- Overflow: event on bit 5, second event on bit 5 before it is granted → overflow=1, bit 5 offered once. Pulse clr_overflow → overflow=0. Coincident new overflow and clr_overflow → overflow stays 1.
- Set/clear collision: while idx_out=9 is offered, assert handshake and word_in bit 9 in the same cycle → pending[9] remains 1, overflow=0, index 9 is offered again.
- Reset mid-operation: pending=32'hFFFF_FFFF, idx_valid=1, assert rst for one edge → all outputs 0. Random one-hot decoder words (200 cycles, random idx_ready) → every event index emitted exactly once unless flagged by overflow.

Source files
------------

// File: rtl/pending_event_encoder_32x5.sv
// -----------------------------------------------------------------------------
// pending_event_encoder_32x5
//
// Purpose:
//   Sits after the 5x32 decoder. Every asserted line of the decoder word is
//   latched into a pending register. Pending lines are then re-encoded one at
//   a time into an index and offered over a valid/ready handshake. This turns
//   bursts of decoded strobes into an ordered stream of indices that the next
//   stage can stall.
//
// Parameters:
//   N_LINES  number of event lines (decoder word width); must equal 2**IDX_W
//   IDX_W    index width
//   RR_MODE  1 = round-robin search upward from a rotating pointer,
//            0 = fixed priority, lowest index first
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset, overrides every other input
//   word_in       event strobes; any bit pattern is legal
//   word_en       qualifies word_in
//   idx_out       index currently offered (registered)
//   idx_valid     idx_out is valid (registered)
//   idx_ready     consumer accepts; transfer = idx_valid & idx_ready at an edge
//   pending       current pending register (registered)
//   overflow      sticky flag: an event hit a line that was already pending
//   clr_overflow  clears overflow (a coincident new overflow wins)
// -----------------------------------------------------------------------------
module pending_event_encoder_32x5 #(
  parameter int N_LINES = 32,
  parameter int IDX_W   = 5,
  parameter bit RR_MODE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] word_in,
  input  logic               word_en,
  output logic [IDX_W-1:0]   idx_out,
  output logic               idx_valid,
  input  logic               idx_ready,
  output logic [N_LINES-1:0] pending,
  output logic               overflow,
  input  logic               clr_overflow
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_reg,    state_next;
  logic [N_LINES-1:0] pending_reg,  pending_next;
  logic [IDX_W-1:0]   idx_reg,      idx_next;
  logic               valid_reg,    valid_next;
  logic [IDX_W-1:0]   ptr_reg,      ptr_next;
  logic               overflow_reg, overflow_next;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Index of the lowest set bit; returns 0 for an all-zero vector (callers
  // only use the result when the vector is non-zero).
  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_LINES-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    // Scanning downward and overwriting leaves the lowest hit in idx.
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // ---------------------------------------------------------------------------
  // Transfer and clear mask
  // ---------------------------------------------------------------------------
  logic               handshake;
  logic [N_LINES-1:0] idx_onehot;
  logic [N_LINES-1:0] clr_mask;
  logic [N_LINES-1:0] set_mask;
  logic [IDX_W-1:0]   ptr_after;

  assign handshake = (state_reg == OFFER) && idx_ready;
  assign set_mask  = word_en ? word_in : '0;
  // Natural IDX_W-bit wrap gives 31 + 1 -> 0.
  assign ptr_after = idx_reg + IDX_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < N_LINES; gi++) begin : g_onehot
      assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign clr_mask = handshake ? idx_onehot : '0;

  // ---------------------------------------------------------------------------
  // Arbitration
  //
  // Round-robin is built as "lowest set bit at or above the pointer, else the
  // lowest set bit overall", which is the same as an upward search with wrap.
  // Two arbiters run in parallel: one over the whole pending register with the
  // stored pointer (used from IDLE) and one over the remaining candidates with
  // the pointer that the current handshake is about to produce (used for
  // back-to-back offers).
  // ---------------------------------------------------------------------------
  logic [N_LINES-1:0] upper_idle;   // lines at or above ptr_reg
  logic [N_LINES-1:0] upper_next;   // lines at or above ptr_after
  logic [N_LINES-1:0] cand_idle;
  logic [N_LINES-1:0] cand_next;
  logic [N_LINES-1:0] hi_idle;
  logic [N_LINES-1:0] hi_next;
  logic [IDX_W-1:0]   arb_idle;
  logic [IDX_W-1:0]   arb_next;

  generate
    for (gi = 0; gi < N_LINES; gi++) begin : g_upper
      assign upper_idle[gi] = (IDX_W'(gi) >= ptr_reg);
      assign upper_next[gi] = (IDX_W'(gi) >= ptr_after);
    end
  endgenerate

  // Candidates after a transfer come from the registered pending only; an
  // event arriving in the same cycle is picked up on a later pass.
  assign cand_idle = pending_reg;
  assign cand_next = pending_reg & ~idx_onehot;
  assign hi_idle   = cand_idle & upper_idle;
  assign hi_next   = cand_next & upper_next;

  always_comb begin
    arb_idle = lowest_set(cand_idle);
    arb_next = lowest_set(cand_next);
    if (RR_MODE) begin
      if (hi_idle != '0) begin
        arb_idle = lowest_set(hi_idle);
      end
      if (hi_next != '0) begin
        arb_next = lowest_set(hi_next);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending register and overflow
  //
  // Set wins over clear: a line re-triggered in the cycle it is transferred
  // stays pending and is offered again. That case is not an overflow because
  // the earlier occurrence has just been consumed.
  // ---------------------------------------------------------------------------
  logic overflow_hit;

  assign pending_next  = (pending_reg & ~clr_mask) | set_mask;
  assign overflow_hit  = |(set_mask & pending_reg & ~clr_mask);

  always_comb begin
    overflow_next = overflow_reg;
    if (overflow_hit) begin
      overflow_next = 1'b1;
    end else if (clr_overflow) begin
      overflow_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Offer FSM (next state / next outputs)
  //
  // idx_out and idx_valid only change on a transfer or when leaving IDLE, so
  // the offer is stable under back-pressure whatever new events arrive.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ptr_next   = ptr_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE: begin
        if (pending_reg != '0) begin
          idx_next   = arb_idle;
          valid_next = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (handshake) begin
          ptr_next = ptr_after;
          if (cand_next != '0) begin
            idx_next = arb_next;
          end else begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      idx_reg      <= '0;
      valid_reg    <= 1'b0;
      ptr_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      idx_reg      <= idx_next;
      valid_reg    <= valid_next;
      ptr_reg      <= ptr_next;
      overflow_reg <= overflow_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // ---------------------------------------------------------------------------
  assign idx_out   = idx_reg;
  assign idx_valid = valid_reg;
  assign pending   = pending_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_pending_event_encoder_32x5.sv
// -----------------------------------------------------------------------------
// tb_pending_event_encoder_32x5
//
// Directed sequence plus a random phase for pending_event_encoder_32x5.
// A round-robin instance (dut) is the main target; a fixed-priority instance
// (dut_fp) shares all inputs and is checked at the arbitration-order points.
// Expected indices are pushed to a queue when the stimulus is driven and
// popped by a monitor on every transfer of the round-robin instance.
// -----------------------------------------------------------------------------
module tb_pending_event_encoder_32x5;

  logic        clk;
  logic        rst;
  logic [31:0] word_in;
  logic        word_en;
  logic        idx_ready;
  logic        clr_overflow;

  logic [4:0]  idx_out;
  logic        idx_valid;
  logic [31:0] pending;
  logic        overflow;

  logic [4:0]  fp_idx_out;
  logic        fp_idx_valid;
  logic [31:0] fp_pending;
  logic        fp_overflow;

  int          checks = 0;
  int          errors = 0;

  int          exp_q[$];
  bit          rnd_mode = 1'b0;
  logic [31:0] model_pend = '0;
  int          ev_cnt = 0;
  int          emit_cnt = 0;

  pending_event_encoder_32x5 #(.N_LINES(32), .IDX_W(5), .RR_MODE(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .word_in      (word_in),
    .word_en      (word_en),
    .idx_out      (idx_out),
    .idx_valid    (idx_valid),
    .idx_ready    (idx_ready),
    .pending      (pending),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  pending_event_encoder_32x5 #(.N_LINES(32), .IDX_W(5), .RR_MODE(1'b0)) dut_fp (
    .clk          (clk),
    .rst          (rst),
    .word_in      (word_in),
    .word_en      (word_en),
    .idx_out      (fp_idx_out),
    .idx_valid    (fp_idx_valid),
    .idx_ready    (idx_ready),
    .pending      (fp_pending),
    .overflow     (fp_overflow),
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a transfer happens at the next edge when valid and
  // ready are both high mid-cycle.
  always @(negedge clk) begin
    int exp_idx;
    if (!rst && idx_valid && idx_ready) begin
      if (!rnd_mode) begin
        check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_idx = exp_q.pop_front();
          check("sb_idx", 32'(idx_out), 32'(exp_idx));
          $display("xfer idx=%0d expected=%0d", idx_out, exp_idx);
        end
      end else begin
        check("rnd_was_pending", 32'(model_pend[idx_out]), 32'd1);
        model_pend[idx_out] = 1'b0;
        emit_cnt++;
        $display("xfer idx=%0d (random phase)", idx_out);
      end
    end
  end

  initial begin
    int line;

    // ---------------- reset ----------------
    rst = 1'b1; word_in = '0; word_en = 1'b0; idx_ready = 1'b0; clr_overflow = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_pending", pending, 32'h0);
    check("rst_valid", 32'(idx_valid), 32'd0);
    check("rst_idx", 32'(idx_out), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // ---------------- single event ----------------
    exp_q.push_back(8);
    word_en = 1'b1; word_in = 32'h0000_0100; idx_ready = 1'b1;
    tick();
    word_en = 1'b0; word_in = '0;
    check("single_pend_e1", pending, 32'h100);
    check("single_valid_e1", 32'(idx_valid), 32'd0);
    tick();
    check("single_valid_e2", 32'(idx_valid), 32'd1);
    check("single_idx_e2", 32'(idx_out), 32'd8);
    tick();
    check("single_pend_e3", pending, 32'h0);
    check("single_valid_e3", 32'(idx_valid), 32'd0);
    check("single_ovf", 32'(overflow), 32'd0);

    // ---------------- burst with backpressure (pointer reset to 0) ----------
    rst = 1'b1; tick(); rst = 1'b0;
    idx_ready = 1'b0;
    word_en = 1'b1;
    word_in = 32'h1 << 3;  tick();
    word_in = 32'h1 << 17; tick();
    word_in = 32'h1 << 30; tick();
    word_en = 1'b0; word_in = '0;
    check("burst_stall_valid", 32'(idx_valid), 32'd1);
    check("burst_stall_idx0", 32'(idx_out), 32'd3);
    tick();
    check("burst_stall_idx1", 32'(idx_out), 32'd3);
    tick();
    check("burst_stall_idx2", 32'(idx_out), 32'd3);
    check("burst_pend", pending, (32'h1 << 3) | (32'h1 << 17) | (32'h1 << 30));
    exp_q.push_back(3); exp_q.push_back(17); exp_q.push_back(30);
    idx_ready = 1'b1;
    tick();
    check("burst_idx17", 32'(idx_out), 32'd17);
    check("burst_valid17", 32'(idx_valid), 32'd1);
    tick();
    check("burst_idx30", 32'(idx_out), 32'd30);
    tick();
    check("burst_done_valid", 32'(idx_valid), 32'd0);
    check("burst_done_pend", pending, 32'h0);

    // ---------------- round-robin wrap (pointer now 31) ----------------
    idx_ready = 1'b0;
    exp_q.push_back(31); exp_q.push_back(2);
    word_en = 1'b1; word_in = (32'h1 << 31) | (32'h1 << 2);
    tick();
    word_en = 1'b0; word_in = '0;
    tick();
    check("wrap_idx31", 32'(idx_out), 32'd31);
    check("wrap_fp_idx2", 32'(fp_idx_out), 32'd2);
    idx_ready = 1'b1;
    tick();
    check("wrap_idx2", 32'(idx_out), 32'd2);
    check("wrap_fp_idx31", 32'(fp_idx_out), 32'd31);
    tick();
    check("wrap_done", 32'(idx_valid), 32'd0);
    check("wrap_fp_done", 32'(fp_idx_valid), 32'd0);

    // pointer should now be 3: lines 1 and 5 give 5 first in round-robin
    idx_ready = 1'b0;
    exp_q.push_back(5); exp_q.push_back(1);
    word_en = 1'b1; word_in = (32'h1 << 1) | (32'h1 << 5);
    tick();
    word_en = 1'b0; word_in = '0;
    tick();
    check("ptr3_idx5", 32'(idx_out), 32'd5);
    check("ptr3_fp_idx1", 32'(fp_idx_out), 32'd1);
    idx_ready = 1'b1;
    tick();
    check("ptr3_idx1", 32'(idx_out), 32'd1);
    check("ptr3_fp_idx5", 32'(fp_idx_out), 32'd5);
    tick();
    check("ptr3_done", 32'(idx_valid), 32'd0);

    // ---------------- overflow ----------------
    idx_ready = 1'b0;
    word_en = 1'b1; word_in = 32'h1 << 5;
    tick();
    check("ovf_not_yet", 32'(overflow), 32'd0);
    tick();
    word_en = 1'b0; word_in = '0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_idx5", 32'(idx_out), 32'd5);
    exp_q.push_back(5);
    idx_ready = 1'b1;
    tick();
    check("ovf_once_valid", 32'(idx_valid), 32'd0);
    check("ovf_once_pend", pending, 32'h0);
    tick();
    check("ovf_no_replay", 32'(idx_valid), 32'd0);
    idx_ready = 1'b0;
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    word_en = 1'b1; word_in = 32'h1 << 7;
    tick();
    clr_overflow = 1'b1;
    tick();
    word_en = 1'b0; word_in = '0; clr_overflow = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    exp_q.push_back(7);
    idx_ready = 1'b1;
    tick();
    check("ovf7_done", 32'(idx_valid), 32'd0);
    idx_ready = 1'b0;
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_cleared2", 32'(overflow), 32'd0);

    // ---------------- set/clear collision on line 9 ----------------
    word_en = 1'b1; word_in = 32'h1 << 9;
    tick();
    word_en = 1'b0; word_in = '0;
    tick();
    check("coll_idx9", 32'(idx_out), 32'd9);
    exp_q.push_back(9); exp_q.push_back(9);
    idx_ready = 1'b1; word_en = 1'b1; word_in = 32'h1 << 9;
    tick();
    word_en = 1'b0; word_in = '0;
    check("coll_pend9", pending, 32'h1 << 9);
    check("coll_ovf", 32'(overflow), 32'd0);
    tick();
    check("coll_reoffer_valid", 32'(idx_valid), 32'd1);
    check("coll_reoffer_idx", 32'(idx_out), 32'd9);
    tick();
    check("coll_done_valid", 32'(idx_valid), 32'd0);
    check("coll_done_pend", pending, 32'h0);
    idx_ready = 1'b0;

    // ---------------- reset mid-operation ----------------
    word_en = 1'b1; word_in = 32'hFFFF_FFFF;
    tick();
    word_en = 1'b0; word_in = '0;
    tick();
    check("midrst_pend_full", pending, 32'hFFFF_FFFF);
    check("midrst_valid_pre", 32'(idx_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_pend", pending, 32'h0);
    check("midrst_valid", 32'(idx_valid), 32'd0);
    check("midrst_idx", 32'(idx_out), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    idx_ready = 1'b1;
    tick(); tick();
    check("midrst_no_replay", 32'(idx_valid), 32'd0);
    idx_ready = 1'b0;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- random one-hot events ----------------
    rnd_mode = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      idx_ready = 1'($urandom_range(0, 1));
      line = int'($urandom_range(0, 31));
      // Only fire lines that are not already pending so no event is lost
      // to overflow and each must come out exactly once.
      if ($urandom_range(0, 1) == 1 && model_pend[line] == 1'b0) begin
        word_en = 1'b1;
        word_in = 32'h1 << line;
        model_pend[line] = 1'b1;
        ev_cnt++;
      end else begin
        word_en = 1'b0;
        word_in = '0;
      end
      tick();
    end
    word_en = 1'b0; word_in = '0; idx_ready = 1'b1;
    for (int w = 0; w < 200 && (model_pend != 32'h0 || idx_valid); w++) begin
      tick();
    end
    tick();
    check("rnd_drain_model", model_pend, 32'h0);
    check("rnd_drain_valid", 32'(idx_valid), 32'd0);
    check("rnd_drain_pend", pending, 32'h0);
    check("rnd_emit_count", 32'(emit_cnt), 32'(ev_cnt));
    check("rnd_ovf", 32'(overflow), 32'd0);
    $display("random phase events=%0d emitted=%0d", ev_cnt, emit_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
